cam_dvp_tx: RTL and testbench

CAM_DVP_TX -- requirements
Module: cam_dvp_tx

---
 rtl/cam_dvp_pkg.sv | 32 +++
 rtl/cam_dvp_tx_if.sv | 24 ++
 rtl/cam_dvp_timing.sv | 60 ++++++
 rtl/cam_dvp_tx.sv | 115 +++++++++++
 tb/tb_cam_dvp_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_dvp_pkg.sv
// Shared constants, state encodings and types for the DVP camera transmitter.
package cam_dvp_pkg;

  localparam int unsigned H_ACTIVE_DEF    = 320;
  localparam int unsigned V_ACTIVE_DEF    = 240;
  localparam int unsigned H_BLANK_DEF     = 144;
  localparam int unsigned VSYNC_LINES_DEF = 3;
  localparam int unsigned VBP_LINES_DEF   = 17;
  localparam int unsigned VFP_LINES_DEF   = 10;

  localparam int unsigned FRAME_PIX_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;

  localparam int unsigned PIX_W  = 16;
  localparam int unsigned BYTE_W = 10;
  localparam int unsigned LINE_W = 11;
  localparam int unsigned CYC_W  = 16;
  localparam int unsigned ADDR_W = $clog2(FRAME_PIX_DEF);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFP    = 3'd5;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic int unsigned line_cyc(input int unsigned h_active, input int unsigned h_blank);
    return 2 * h_active + h_blank;
  endfunction

endpackage

// File: rtl/cam_dvp_tx_if.sv
// Frame-buffer read port plus DVP video outputs of the camera transmitter.
interface cam_dvp_tx_if;
  import cam_dvp_pkg::*;

  logic              en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  pix_t              rd_data;
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              frame_done;
  logic              busy;

  modport master (
    input  en, rd_data,
    output rd_en, rd_addr, vsync, href, d, frame_done, busy
  );

  modport slave (
    output en, rd_data,
    input  rd_en, rd_addr, vsync, href, d, frame_done, busy
  );
endinterface

// File: rtl/cam_dvp_timing.sv
// Per-state cycle, byte and line counters; exposes end-of-state strobe and next counter values.
module cam_dvp_timing
  import cam_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_BLANK     = H_BLANK_DEF,
  parameter int unsigned VSYNC_LINES = VSYNC_LINES_DEF,
  parameter int unsigned VBP_LINES   = VBP_LINES_DEF,
  parameter int unsigned VFP_LINES   = VFP_LINES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        state,
  output logic              done_c,
  output logic [BYTE_W-1:0] byte_nxt_c,
  output logic [CYC_W-1:0]  cyc_nxt_c,
  output logic [LINE_W-1:0] line_nxt_c
);
  localparam int unsigned LINE_CYC  = line_cyc(H_ACTIVE, H_BLANK);
  localparam int unsigned VSYNC_LEN = VSYNC_LINES * LINE_CYC;
  localparam int unsigned VBP_LEN   = VBP_LINES * LINE_CYC;
  localparam int unsigned VFP_LEN   = VFP_LINES * LINE_CYC;

  logic [BYTE_W-1:0] byte_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [LINE_W-1:0] line_cnt;

  // Byte counter runs only in ACTIVE; the cycle counter covers porches and HBLANK.
  always_comb begin
    done_c = 1'b0;
    case (state)
      S_VSYNC:  done_c = (cyc_cnt == CYC_W'(VSYNC_LEN - 1));
      S_VBP:    done_c = (cyc_cnt == CYC_W'(VBP_LEN - 1));
      S_ACTIVE: done_c = (byte_cnt == BYTE_W'(2 * H_ACTIVE - 1));
      S_HBLANK: done_c = (cyc_cnt == CYC_W'(H_BLANK - 1));
      S_VFP:    done_c = (cyc_cnt == CYC_W'(VFP_LEN - 1));
      default:  done_c = 1'b0;
    endcase
    byte_nxt_c = (state == S_ACTIVE && !done_c) ? byte_cnt + BYTE_W'(1) : '0;
    cyc_nxt_c  = (state == S_IDLE || state == S_ACTIVE || done_c) ? '0 : cyc_cnt + CYC_W'(1);
    if (state == S_VSYNC)
      line_nxt_c = '0;
    else if (state == S_ACTIVE && done_c)
      line_nxt_c = line_cnt + LINE_W'(1);
    else
      line_nxt_c = line_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      cyc_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      byte_cnt <= byte_nxt_c;
      cyc_cnt  <= cyc_nxt_c;
      line_cnt <= line_nxt_c;
    end
  end
endmodule

// File: rtl/cam_dvp_tx.sv
// Frame-buffer to DVP transmitter: frame FSM, pixel read issue and RGB565 byte serialiser.
module cam_dvp_tx
  import cam_dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned H_BLANK     = H_BLANK_DEF,
  parameter int unsigned VSYNC_LINES = VSYNC_LINES_DEF,
  parameter int unsigned VBP_LINES   = VBP_LINES_DEF,
  parameter int unsigned VFP_LINES   = VFP_LINES_DEF
) (
  input  logic         pclk,
  input  logic         rst,
  cam_dvp_tx_if.master bus
);
  localparam int unsigned LINE_CYC = line_cyc(H_ACTIVE, H_BLANK);
  localparam int unsigned VBP_LEN  = VBP_LINES * LINE_CYC;
  localparam int unsigned VFP_LEN  = VFP_LINES * LINE_CYC;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              done_c;
  logic [BYTE_W-1:0] byte_nxt_c;
  logic [CYC_W-1:0]  cyc_nxt_c;
  logic [LINE_W-1:0] line_nxt_c;
  logic              read_c;
  logic              frame_done_c;
  logic              vs_entry_c;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        lo_byte;

  cam_dvp_timing #(
    .H_ACTIVE   (H_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LINES(VSYNC_LINES),
    .VBP_LINES  (VBP_LINES),
    .VFP_LINES  (VFP_LINES)
  ) u_timing (
    .clk       (pclk),
    .rst       (rst),
    .state     (state),
    .done_c    (done_c),
    .byte_nxt_c(byte_nxt_c),
    .cyc_nxt_c (cyc_nxt_c),
    .line_nxt_c(line_nxt_c)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    state_nxt    = state;
    read_c       = 1'b0;
    frame_done_c = 1'b0;
    case (state)
      S_IDLE:   if (bus.en) state_nxt = S_VSYNC;
      S_VSYNC:  if (done_c) state_nxt = S_VBP;
      S_VBP:    if (done_c) state_nxt = S_ACTIVE;
      S_ACTIVE: if (done_c) state_nxt = S_HBLANK;
      S_HBLANK: if (done_c) state_nxt = (line_nxt_c < LINE_W'(V_ACTIVE)) ? S_ACTIVE : S_VFP;
      S_VFP:    if (done_c) state_nxt = bus.en ? S_VSYNC : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // A pixel is fetched two cycles ahead of its high byte.
    if (state_nxt == S_ACTIVE)
      read_c = !byte_nxt_c[0] && (byte_nxt_c < BYTE_W'(2 * H_ACTIVE - 2));
    else if (state_nxt == S_VBP)
      read_c = (cyc_nxt_c == CYC_W'(VBP_LEN - 2));
    else if (state_nxt == S_HBLANK)
      read_c = (cyc_nxt_c == CYC_W'(H_BLANK - 2)) && (line_nxt_c < LINE_W'(V_ACTIVE));
    frame_done_c = (state_nxt == S_VFP) && (cyc_nxt_c == CYC_W'(VFP_LEN - 1));
    vs_entry_c   = (state_nxt == S_VSYNC) && (state != S_VSYNC);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      bus.vsync      <= 1'b0;
      bus.href       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.rd_addr    <= '0;
      bus.d          <= '0;
      addr_cnt       <= '0;
      lo_byte        <= '0;
    end else begin
      bus.vsync      <= (state_nxt == S_VSYNC);
      bus.href       <= (state_nxt == S_ACTIVE);
      bus.busy       <= (state_nxt != S_IDLE);
      bus.frame_done <= frame_done_c;
      bus.rd_en      <= read_c;
      if (vs_entry_c) begin
        bus.rd_addr <= '0;
        addr_cnt    <= '0;
      end else if (read_c) begin
        bus.rd_addr <= addr_cnt;
        addr_cnt    <= addr_cnt + ADDR_W'(1);
      end
      // High byte straight from the read port; low byte from the holding register.
      if (state_nxt == S_ACTIVE) begin
        if (!byte_nxt_c[0]) begin
          bus.d   <= bus.rd_data[15:8];
          lo_byte <= bus.rd_data[7:0];
        end else begin
          bus.d <= lo_byte;
        end
      end else begin
        bus.d <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cam_dvp_tx.sv
// Self-checking bench for cam_dvp_tx: frame-position reference model, RAM model and DVP capture receiver.
module tb_cam_dvp_tx;
  import cam_dvp_pkg::*;

  localparam int H = 4, V = 3, HB = 2, VSL = 1, VBPL = 1, VFPL = 1;
  localparam int LINE    = 2 * H + HB;
  localparam int ACT0    = (VSL + VBPL) * LINE;
  localparam int ACT_LEN = V * LINE;
  localparam int FRAME   = (VSL + VBPL + V + VFPL) * LINE;

  logic pclk = 1'b0;
  logic rst;
  cam_dvp_tx_if bus();

  cam_dvp_tx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
    .VSYNC_LINES(VSL), .VBP_LINES(VBPL), .VFP_LINES(VFPL)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-buffer RAM: one-cycle read latency.
  always @(posedge pclk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[3:0]];

  // Reference model: position within the frame decides every output.
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  logic [16:0] m_addr = '0;

  function automatic bit act_at(input int t);
    int a = t - ACT0;
    return (a >= 0) && (a < ACT_LEN) && ((a % LINE) < 2 * H);
  endfunction

  function automatic int pix_at(input int t);
    int a = t - ACT0;
    return (a / LINE) * H + (a % LINE) / 2;
  endfunction

  function automatic bit hi_at(input int t);
    return ((t - ACT0) % LINE) % 2 == 0;
  endfunction

  always @(posedge pclk) begin
    if (rst) begin
      m_run = 1'b0; m_t = 0; m_addr = '0;
    end else if (!m_run) begin
      if (bus.en) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == FRAME - 1) begin
      if (bus.en) m_t = 0;
      else        m_run = 1'b0;
    end else begin
      m_t++;
    end
    if (m_run && m_t == 0) m_addr = '0;
    if (m_run && act_at(m_t + 2) && hi_at(m_t + 2)) m_addr = 17'(pix_at(m_t + 2));
  end

  function automatic logic [29:0] model_out();
    logic vs, hr, rde, fd, bz;
    logic [7:0] dd;
    logic [15:0] px;
    vs = 1'b0; hr = 1'b0; rde = 1'b0; fd = 1'b0; bz = 1'b0; dd = '0;
    if (m_run) begin
      bz = 1'b1;
      vs = (m_t < VSL * LINE);
      fd = (m_t == FRAME - 1);
      rde = act_at(m_t + 2) && hi_at(m_t + 2);
      if (act_at(m_t)) begin
        hr = 1'b1;
        px = mem[4'(pix_at(m_t))];
        dd = hi_at(m_t) ? px[15:8] : px[7:0];
      end
    end
    return {vs, hr, dd, rde, m_addr, fd, bz};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {bus.vsync, bus.href, bus.d, bus.rd_en, bus.rd_addr, bus.frame_done, bus.busy};
  endfunction

  always @(negedge pclk) begin
    if (rst) check("outputs_rst", 32'(dut_vec()), 32'd0);
    else     check("outputs", 32'(dut_vec()), 32'(model_out()));
  end

  // Event monitors and loopback capture receiver.
  int          rd_cnt, fd_cnt, vs_cnt, rise_fd, hlen, widx;
  int          hq[$];
  logic [7:0]  dq[$];
  logic [16:0] max_addr, first_addr;
  bit          first_pend, ph, prev_fd, prev_vs;
  logic [7:0]  hi;
  logic [15:0] cap [16];

  always @(negedge pclk) begin
    if (bus.rd_en) begin
      rd_cnt++;
      if (bus.rd_addr > max_addr) max_addr = bus.rd_addr;
      if (first_pend) begin first_addr = bus.rd_addr; first_pend = 1'b0; end
    end
    if (bus.frame_done) fd_cnt++;
    if (bus.vsync) begin vs_cnt++; widx = 0; end
    if (prev_fd && bus.vsync && !prev_vs) rise_fd++;
    if (bus.href) begin
      hlen++;
      dq.push_back(bus.d);
      if (!ph) hi = bus.d;
      else begin
        if (widx < 16) cap[widx] = {hi, bus.d};
        widx++;
      end
      ph = !ph;
    end else begin
      if (hlen != 0) hq.push_back(hlen);
      hlen = 0;
      ph = 1'b0;
    end
    prev_fd = bus.frame_done;
    prev_vs = bus.vsync;
  end

  task automatic clear();
    rd_cnt = 0; fd_cnt = 0; vs_cnt = 0; rise_fd = 0; hlen = 0; widx = 0;
    hq.delete(); dq.delete();
    max_addr = '0; first_addr = '1; first_pend = 1'b1; ph = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #2;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
  endtask

  task automatic wait_frames(input string name, input int want);
    for (int i = 0; i < 8 * FRAME && !(fd_cnt >= want && !bus.busy); i++) step(1);
    check(name, 32'(fd_cnt >= want && !bus.busy), 32'd1);
  endtask

  task automatic check_capture(input string name);
    check({name, "_count"}, 32'(widx), 32'(H * V));
    for (int i = 0; i < H * V; i++) check({name, "_pix"}, 32'(cap[i]), 32'(mem[i]));
  endtask

  logic [7:0] exp_bytes [10] = '{8'hA0, 8'h00, 8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h03, 8'hA0, 8'h04};

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    clear();
    step(3);
    check("reset_state", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    step(2);

    // Single frame with address-pattern RAM
    clear();
    bus.en = 1'b1;
    step(1);
    bus.en = 1'b0;
    wait_frames("frame_a_end", 1);
    check("a_vsync_cycles", 32'(vs_cnt), 32'd10);
    check("a_href_pulses", 32'(hq.size()), 32'd3);
    for (int i = 0; i < hq.size(); i++) check("a_href_len", 32'(hq[i]), 32'd8);
    check("a_byte_count", 32'(dq.size()), 32'd24);
    for (int i = 0; i < 10; i++) check("a_byte_seq", 32'(dq[i]), 32'(exp_bytes[i]));
    check("a_reads", 32'(rd_cnt), 32'd12);
    check("a_max_addr", 32'(max_addr), 32'd11);
    check("a_final_addr", 32'(bus.rd_addr), 32'd11);
    check("a_frame_done", 32'(fd_cnt), 32'd1);
    check_capture("a_loopback");
    step($urandom_range(1, 6));

    // en dropped during line 1
    randomize_mem();
    clear();
    bus.en = 1'b1;
    step(1);
    step(ACT0 + LINE + int'($urandom_range(0, 7)));
    bus.en = 1'b0;
    wait_frames("frame_b_end", 1);
    check("b_busy_low", 32'(bus.busy), 32'd0);
    check("b_frame_done", 32'(fd_cnt), 32'd1);
    check_capture("b_loopback");
    step(3);
    check("b_vsync_stays_low", 32'({bus.vsync, bus.busy}), 32'd0);
    step($urandom_range(1, 6));

    // Reset pulsed during line 2, en held high through release
    randomize_mem();
    clear();
    bus.en = 1'b1;
    step(1);
    step(ACT0 + 2 * LINE + int'($urandom_range(0, 9)));
    rst = 1'b1;
    #1;
    check("c_rst_immediate", 32'(dut_vec()), 32'd0);
    step(1);
    clear();
    rst = 1'b0;
    step(3);
    bus.en = 1'b0;
    wait_frames("frame_c_end", 1);
    check("c_frame_done", 32'(fd_cnt), 32'd1);
    check("c_first_addr", 32'(first_addr), 32'd0);
    check("c_reads", 32'(rd_cnt), 32'd12);
    check_capture("c_loopback");
    step($urandom_range(1, 6));

    // Three back-to-back frames
    randomize_mem();
    clear();
    bus.en = 1'b1;
    for (int i = 0; i < 4 * FRAME && fd_cnt < 2; i++) step(1);
    check("d_two_frames", 32'(fd_cnt >= 2), 32'd1);
    step(5);
    bus.en = 1'b0;
    wait_frames("frame_d_end", 3);
    check("d_reads", 32'(rd_cnt), 32'd36);
    check("d_frame_done", 32'(fd_cnt), 32'd3);
    check("d_vsync_after_done", 32'(rise_fd), 32'd2);
    check_capture("d_loopback");
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
